// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles big-endian 16-bit words from a byte stream and writes them out.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the CPU.
module imem_loader #(
    parameter int ADDR_W   = 8,
    parameter int LOAD_LEN = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              cpu_run,
    output logic              checksum_ok
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] LOAD_LEN_W = (ADDR_W+1)'(LOAD_LEN);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              xfer;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       chk_ok_q, chk_ok_d;
`endif

    assign xfer = in_valid && in_ready;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        word_count_d = word_count_q;
        in_ready     = 1'b0;
        wr_en        = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
        chk_ok_d     = chk_ok_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_HI;
                    wr_addr_d    = '0;
                    word_count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d       = 8'h00;
                    chk_ok_d     = 1'b0;
`endif
                end
            end
            S_HI: begin
                in_ready = 1'b1;
                if (xfer) begin
                    wr_data_d[15:8] = in_data;
                    state_d         = S_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d          = csum_q ^ in_data;
`endif
                end
            end
            S_LO: begin
                in_ready = 1'b1;
                if (xfer) begin
                    wr_data_d[7:0] = in_data;
                    state_d        = S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d         = csum_q ^ in_data;
`endif
                end
            end
            S_WRITE: begin
                wr_en        = 1'b1;
                wr_addr_d    = wr_addr_q + 1'b1;
                word_count_d = word_count_q + 1'b1;
                // word_count_d already holds the post-write count, so this is the last-word test.
                if (word_count_d == LOAD_LEN_W) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_HI;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                if (xfer) begin
                    chk_ok_d = (csum_q == in_data);
                    state_d  = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            word_count_q <= word_count_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q   <= 8'h00;
            chk_ok_q <= 1'b0;
        end else begin
            csum_q   <= csum_d;
            chk_ok_q <= chk_ok_d;
        end
    end

    assign checksum_ok = chk_ok_q;
`else
    assign checksum_ok = 1'b1;
`endif

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign word_count = word_count_q;
    assign done       = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign cpu_run    = done && checksum_ok;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a LOAD_LEN=4 instance for function/boundary steps
// and a LOAD_LEN=256 instance for a full load with gaps in the byte stream.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start, in_valid;
    logic [7:0] in_data;
    logic       in_ready, wr_en, busy, done, cpu_run, checksum_ok;
    logic [7:0] wr_addr;
    logic [15:0] wr_data;
    logic [8:0] word_count;

    logic       b_start, b_in_valid;
    logic [7:0] b_in_data;
    logic       b_in_ready, b_wr_en, b_busy, b_done, b_cpu_run, b_checksum_ok;
    logic [7:0] b_wr_addr;
    logic [15:0] b_wr_data;
    logic [8:0] b_word_count;

    imem_loader #(.ADDR_W(8), .LOAD_LEN(4)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .word_count(word_count), .cpu_run(cpu_run),
        .checksum_ok(checksum_ok)
    );

    imem_loader #(.ADDR_W(8), .LOAD_LEN(256)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .done(b_done), .word_count(b_word_count), .cpu_run(b_cpu_run),
        .checksum_ok(b_checksum_ok)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]  stream [8]    = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    logic [15:0] exp_words [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

    // Write-strobe capture for the small instance.
    logic [7:0]  log_addr [$];
    logic [15:0] log_data [$];
    int          ready_in_write = 0;
    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            if (in_ready) ready_in_write++;
        end
    end

    // Big instance: byte i of the stream is i[7:0]^5A, so word k is {(2k)^5A, (2k+1)^5A}.
    int         b_strobes = 0;
    int         b_errs    = 0;
    logic [7:0] b_exp_hi, b_exp_lo;
    always @(negedge clk) begin
        if (b_wr_en) begin
            b_exp_hi = 8'(2 * b_strobes) ^ 8'h5A;
            b_exp_lo = 8'(2 * b_strobes + 1) ^ 8'h5A;
            if (b_wr_addr !== 8'(b_strobes) || b_wr_data !== {b_exp_hi, b_exp_lo} || b_in_ready)
                b_errs++;
            b_strobes++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        else @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_byte_b(input logic [7:0] b);
        int n = 0;
        b_in_valid = 1'b1;
        b_in_data  = b;
        while (!b_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!b_in_ready) check("big_send_timeout", 32'(b_in_ready), 32'd1);
        else @(negedge clk);
        b_in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic send_stream(input logic [7:0] csum_byte);
        for (int i = 0; i < 8; i++) send_byte(stream[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum_byte);
`else
        in_data = csum_byte;
`endif
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwrites"}, 32'(log_addr.size()), 32'd4);
        for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
            check($sformatf("%s_addr%0d", tag, k), 32'(log_addr[k]), 32'(k));
            check($sformatf("%s_data%0d", tag, k), 32'(log_data[k]), 32'(exp_words[k]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_cpu_run"},    32'(cpu_run),    32'd0);
        check({tag, "_wr_en"},      32'(wr_en),      32'd0);
        check({tag, "_in_ready"},   32'(in_ready),   32'd0);
        check({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
        check({tag, "_wr_data"},    32'(wr_data),    32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
        check({tag, "_chk_ok"},     32'(checksum_ok), 32'(!CSUM_EN));
    endtask

    logic [7:0] b_xor;
    int         nb;

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        b_start = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00;
        repeat (2) @(negedge clk);
        check_all_zero("reset");

        // Load 1: start on the first edge after reset release, back-to-back stream.
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("l1_busy", 32'(busy), 32'd1);
        check("l1_in_ready", 32'(in_ready), 32'd1);
        check("l1_chk_ok_during", 32'(checksum_ok), 32'(!CSUM_EN));
        log_addr.delete(); log_data.delete();
        send_byte(stream[0]);
        send_byte(stream[1]);
        check("l1_lat_wr_en", 32'(wr_en), 32'd1);
        check("l1_lat_wr_addr", 32'(wr_addr), 32'd0);
        check("l1_lat_wr_data", 32'(wr_data), 32'h1234);
        check("l1_write_not_ready", 32'(in_ready), 32'd0);
        for (int i = 2; i < 8; i++) send_byte(stream[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        wait_done("l1_done");
        check_writes("l1");
        check("l1_word_count", 32'(word_count), 32'd4);
        check("l1_cpu_run", 32'(cpu_run), 32'd1);
        check("l1_chk_ok", 32'(checksum_ok), 32'd1);
        check("l1_busy_done", 32'(busy), 32'd0);
        check("l1_wr_en_done", 32'(wr_en), 32'd0);

        // Load 2: restart from DONE, ignored start in LO, stall in HI, bad checksum byte.
        pulse_start();
        check("l2_done_drop", 32'(done), 32'd0);
        check("l2_cpu_run_drop", 32'(cpu_run), 32'd0);
        check("l2_word_count_clr", 32'(word_count), 32'd0);
        check("l2_wr_addr_clr", 32'(wr_addr), 32'd0);
        log_addr.delete(); log_data.delete();
        send_byte(stream[0]);
        pulse_start();
        check("l2_start_in_lo_busy", 32'(busy), 32'd1);
        send_byte(stream[1]);
        repeat (4) @(negedge clk);
        check("l2_stall_word_count", 32'(word_count), 32'd1);
        check("l2_stall_wr_addr", 32'(wr_addr), 32'd1);
        check("l2_stall_wr_en", 32'(wr_en), 32'd0);
        check("l2_stall_in_ready", 32'(in_ready), 32'd1);
        for (int i = 2; i < 8; i++) send_byte(stream[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h01);
`endif
        wait_done("l2_done");
        check_writes("l2");
        check("l2_word_count", 32'(word_count), 32'd4);
        check("l2_chk_ok", 32'(checksum_ok), 32'(!CSUM_EN));
        check("l2_cpu_run", 32'(cpu_run), 32'(!CSUM_EN));

        // Load 3: asynchronous reset after three words, then a clean reload.
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(stream[i]);
        @(negedge clk);
        check("l3_words_before_rst", 32'(word_count), 32'd3);
        #2 rst_n = 1'b0;
        #1 check_all_zero("l3_async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        log_addr.delete(); log_data.delete();
        send_stream(8'h00);
        wait_done("l3_done");
        check_writes("l3");
        check("l3_cpu_run", 32'(cpu_run), 32'd1);
        check("ready_in_write", 32'(ready_in_write), 32'd0);

        // Full 256-word load on the big instance with periodic idle gaps.
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_xor = 8'h00;
        for (int i = 0; i < 512; i++) begin
            if (i % 7 == 3) repeat (i % 4) @(negedge clk);
            send_byte_b(8'(i) ^ 8'h5A);
            b_xor = b_xor ^ (8'(i) ^ 8'h5A);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte_b(b_xor);
`endif
        nb = 0;
        while (!b_done && nb < 50) begin
            @(negedge clk);
            nb++;
        end
        check("big_done", 32'(b_done), 32'd1);
        check("big_strobes", 32'(b_strobes), 32'd256);
        check("big_errs", 32'(b_errs), 32'd0);
        check("big_word_count", 32'(b_word_count), 32'd256);
        check("big_wr_addr_wrap", 32'(b_wr_addr), 32'd0);
        check("big_cpu_run", 32'(b_cpu_run), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 Parameter LOAD_LEN, default 256, number of 16-bit words per load (1..2^ADDR_W).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a load.
REQ-006 in_valid  input  1  byte-stream source has a byte.
REQ-007 in_data  input  8  byte from the stream.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 wr_en  output  1  instruction-memory write strobe.
REQ-010 wr_addr  output  ADDR_W  instruction-memory write address.
REQ-011 wr_data  output  16  instruction word to write.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  load completed; held until next start or reset.
REQ-014 word_count  output  ADDR_W+1  words written in the current load.
REQ-015 cpu_run  output  1  releases the processor; high only after a successful load.
REQ-016 checksum_ok  output  1  checksum result (see Configuration).

Function
REQ-017 FSM states: IDLE, HI, LO, WRITE, CHK, DONE; one-hot or binary encoding allowed.
REQ-018 A byte is transferred iff in_valid && in_ready at a rising clk edge; in_ready is high only in HI, LO and CHK.
REQ-019 IDLE or DONE + start -> HI; wr_addr, word_count cleared to 0; done, cpu_run cleared the same edge.
REQ-020 start in HI, LO, WRITE or CHK is ignored.
REQ-021 HI + transfer -> stores in_data as wr_data[15:8]; -> LO.
REQ-022 LO + transfer -> stores in_data as wr_data[7:0]; -> WRITE.
REQ-023 WRITE lasts exactly one cycle with wr_en=1, wr_addr and wr_data stable; latency from low-byte transfer edge to wr_en high is one cycle.
REQ-024 On leaving WRITE: word_count += 1, wr_addr += 1 (modulo 2^ADDR_W).
REQ-025 Leaving WRITE: if word_count+1 == LOAD_LEN -> CHK (macro defined) or DONE (macro undefined); else -> HI.
REQ-026 In DONE: done=1, busy=0, cpu_run=checksum_ok.
REQ-027 busy=1 in HI, LO, WRITE, CHK; 0 in IDLE, DONE.
REQ-028 in_valid with in_ready=0 leaves state unchanged; the source holds its byte.
REQ-029 Stream stall (in_valid=0) in HI/LO/CHK leaves state and outputs unchanged indefinitely.
REQ-030 wr_en is never high outside WRITE; exactly LOAD_LEN write strobes per load.

Reset
REQ-031 rst_n low asynchronously forces IDLE; in_ready, wr_en, busy, done, cpu_run = 0; wr_addr, wr_data, word_count = 0; internal checksum = 0.
REQ-032 Reset during a load aborts it; partially written memory is not cleaned; cpu_run stays 0 until a later load completes.
REQ-033 First start is honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-034 Macro IMEM_LOADER_CHECKSUM_EN selects checksum support.
REQ-035 Defined: 8-bit running XOR of every transferred instruction byte, cleared on start; after the last WRITE, CHK accepts one extra byte; checksum_ok = (running XOR == that byte), registered on entry to DONE; -> DONE.
REQ-036 Defined: checksum_ok = 0 from start until DONE; cpu_run = 0 in DONE on mismatch.
REQ-037 Undefined: no CHK state, no checksum logic; checksum_ok constant 1; DONE follows the last WRITE directly.

Verification
REQ-038 LOAD_LEN=4, bytes 12 34 56 78 9A BC DE F0 streamed back-to-back -> writes (0,1234),(1,5678),(2,9ABC),(3,DEF0), done=1, word_count=4, cpu_run=1 (checksum variant: extra byte 00 -> checksum_ok=1).
REQ-039 Checksum variant, same stream with extra byte 01 -> done=1, checksum_ok=0, cpu_run=0.
REQ-040 Random in_valid gaps, LOAD_LEN=256 -> 256 strobes, addresses 0..255 in order, no duplicate or lost byte, in_ready=0 in every WRITE cycle.
REQ-041 start pulse during LO -> ignored; load completes with original addresses.
REQ-042 rst_n low after 3 words -> all outputs 0 asynchronously; new start reloads from address 0.
REQ-043 start in DONE -> done and cpu_run drop next edge, word_count=0, second load completes normally.
